imem_loader: RTL and testbench

- Byte-stream program loader: the write-side counterpart of the CPU's instruction-memory fetch port.
- Takes a framed byte stream over a valid/ready handshake, typically from a UART RX or a debug bridge.
- Assembles 16-bit instruction words and writes them into instr_mem at consecutive even byte addresses starting at 0.
- Holds the CPU in reset until a complete, valid image has been loaded.

---
 rtl/imem_loader.sv | 243 ++++++++++++++++++++++++
 tb/tb_imem_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : imem_loader                                                |
// | Description : Framed byte-stream program loader. Assembles 16-bit words  |
// |               from a valid/ready byte stream and writes them into        |
// |               instr_mem at consecutive even byte addresses from 0. The   |
// |               CPU is held in reset until a complete image is loaded.     |
// |               Frame: SYNC, LEN_LO, LEN_HI, N x (lo, hi) [, CSUM].         |
// | Option      : `define LOADER_CHECKSUM_EN to require a trailing XOR       |
// |               checksum byte (covers every byte after SYNC).              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module imem_loader #(
    parameter int unsigned ADDR_W    = 9,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    input  logic              start_i,
    output logic              imem_wen_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [15:0]       imem_data_o,
    output logic              cpu_reset_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LEN_LO  = 4'd1,
        ST_LEN_HI  = 4'd2,
        ST_DATA_LO = 4'd3,
        ST_DATA_HI = 4'd4,
        ST_WRITE   = 4'd5,
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM    = 4'd6,
`endif
        ST_DONE    = 4'd7,
        ST_ERR     = 4'd8
    } state_t;

    // Largest image the memory can hold, in words (17 bits so 2^16 fits).
    localparam logic [16:0] c_max_words = 17'd1 << (ADDR_W - 1);
    // Timeout fires when the counter would step onto all-ones.
    localparam logic [TIMEOUT_W-1:0] c_tmo_last = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    localparam logic [TIMEOUT_W-1:0] c_tmo_one  = TIMEOUT_W'(1);

    state_t                state_q, state_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [15:0]           n_q, n_d;
    logic [7:0]            lo_q, lo_d;
    logic [15:0]           idx_q, idx_d;
    logic [TIMEOUT_W-1:0]  tmo_q, tmo_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [15:0]           data_q, data_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            acc_q, acc_d;
`endif

    logic                  rx_ready_q;
    logic                  wen_q;
    logic                  cpu_reset_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;

    logic                  w_accept;
    logic                  w_active;
    logic [15:0]           w_len;
    logic                  w_oversize;
    logic [15:0]           w_idx_inc;

    assign w_accept   = rx_valid_i && rx_ready_q;
    assign w_len      = {rx_data_i, len_lo_q};
    assign w_oversize = ({1'b0, w_len} > c_max_words);
    assign w_idx_inc  = idx_q + 16'd1;
    assign w_active   = (state_q inside {ST_LEN_LO, ST_LEN_HI, ST_DATA_LO, ST_DATA_HI})
`ifdef LOADER_CHECKSUM_EN
                        || (state_q == ST_CSUM)
`endif
                        ;

    // Next-state and datapath decode for the frame parser.
    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        n_d      = n_q;
        lo_d     = lo_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        data_d   = data_q;
        tmo_d    = '0;
`ifdef LOADER_CHECKSUM_EN
        acc_d    = acc_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (w_accept && (rx_data_i == SYNC_BYTE)) begin
                    state_d = ST_LEN_LO;
                    idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                    acc_d   = '0;
`endif
                end
            end
            ST_LEN_LO: begin
                if (w_accept) begin
                    len_lo_d = rx_data_i;
                    state_d  = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (w_accept) begin
                    n_d = w_len;
                    if (w_oversize) begin
                        state_d = ST_ERR;
                    end else if (w_len == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_DATA_LO;
                    end
                end
            end
            ST_DATA_LO: begin
                if (w_accept) begin
                    lo_d    = rx_data_i;
                    state_d = ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                if (w_accept) begin
                    addr_d  = ADDR_W'({idx_q, 1'b0});
                    data_d  = {rx_data_i, lo_q};
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                idx_d = w_idx_inc;
                if (w_idx_inc == n_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = ST_CSUM;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_DATA_LO;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (w_accept) begin
                    state_d = (rx_data_i == acc_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            ST_DONE, ST_ERR: begin
                if (start_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef LOADER_CHECKSUM_EN
        // Every byte after SYNC except the checksum itself feeds the XOR.
        if (w_accept && (state_q inside {ST_LEN_LO, ST_LEN_HI, ST_DATA_LO, ST_DATA_HI})) begin
            acc_d = acc_q ^ rx_data_i;
        end
`endif

        // Idle cycles inside a frame count toward the timeout; an accepted
        // byte or any state change leaves the counter at its cleared default.
        if (w_active && !w_accept) begin
            if (tmo_q == c_tmo_last) begin
                state_d = ST_ERR;
            end else begin
                tmo_d = tmo_q + c_tmo_one;
            end
        end
    end

    // State register with outputs decoded from the next state so they are registered.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_lo_q    <= '0;
            n_q         <= '0;
            lo_q        <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
            acc_q       <= '0;
`endif
            rx_ready_q  <= 1'b1;
            wen_q       <= 1'b0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            n_q         <= n_d;
            lo_q        <= lo_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
`ifdef LOADER_CHECKSUM_EN
            acc_q       <= acc_d;
`endif
            rx_ready_q  <= !(state_d inside {ST_WRITE, ST_DONE, ST_ERR});
            wen_q       <= (state_d == ST_WRITE);
            cpu_reset_q <= (state_d != ST_DONE);
            busy_q      <= !(state_d inside {ST_IDLE, ST_DONE, ST_ERR});
            done_q      <= (state_d == ST_DONE);
            error_q     <= (state_d == ST_ERR);
        end
    end

    assign rx_ready_o  = rx_ready_q;
    assign imem_wen_o  = wen_q;
    assign imem_addr_o = addr_q;
    assign imem_data_o = data_q;
    assign cpu_reset_o = cpu_reset_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_imem_loader                                             |
// | Description : Self-checking bench for imem_loader. Expected instr_mem    |
// |               writes are queued as frames are driven and popped when the |
// |               DUT strobes imem_wen_o. Honours LOADER_CHECKSUM_EN.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_imem_loader;

    localparam int unsigned ADDR_W = 9;

    logic              clk_i = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        rx_data_i = 8'h00;
    logic              rx_valid_i = 1'b0;
    logic              rx_ready_o;
    logic              start_i = 1'b0;
    logic              imem_wen_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [15:0]       imem_data_o;
    logic              cpu_reset_o;
    logic              busy_o;
    logic              done_o;
    logic              error_o;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    wr_t exp_q[$];
    wr_t exp_w;
    int  n_cmp    = 0;
    int  n_bad    = 0;
    int  n_writes = 0;

    imem_loader #(
        .ADDR_W   (ADDR_W),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_W(4)
    ) dut (
        .clk_i      (clk_i),
        .reset      (reset),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .rx_ready_o (rx_ready_o),
        .start_i    (start_i),
        .imem_wen_o (imem_wen_o),
        .imem_addr_o(imem_addr_o),
        .imem_data_o(imem_data_o),
        .cpu_reset_o(cpu_reset_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .error_o    (error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest queued expectation.
    always @(negedge clk_i) begin
        if (imem_wen_o === 1'b1) begin
            n_writes++;
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_bad++;
                $error("FAIL unexpected_write: observed addr %0h data %0h expected no write",
                       imem_addr_o, imem_data_o);
            end
            if (exp_q.size() != 0) begin
                exp_w = exp_q.pop_front();
                check("wr_addr", 32'(imem_addr_o), 32'(exp_w.addr));
                check("wr_data", 32'(imem_data_o), 32'(exp_w.data));
            end
        end
    end

    // Drives one byte from #1 after an edge and holds it until an edge with ready high.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard      = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        while (rx_ready_o !== 1'b1 && guard < 40) begin
            @(posedge clk_i);
            #1;
            guard++;
        end
        if (guard >= 40) begin
            check("send_ready_timeout", 32'(rx_ready_o), 32'd1);
        end else begin
            @(posedge clk_i);
            #1;
        end
        rx_valid_i = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    // Two-word image 0x1234, 0x5678; gap idles the line between the first lo/hi pair.
    task automatic send_good_frame(input logic [7:0] csum, input int gap);
        exp_q.push_back('{addr: 9'h000, data: 16'h1234});
        exp_q.push_back('{addr: 9'h002, data: 16'h5678});
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h34);
        idle_cycles(gap);
        send_byte(8'h12);
        send_byte(8'h78);
        send_byte(8'h56);
`ifdef LOADER_CHECKSUM_EN
        send_byte(csum);
`endif
        idle_cycles(2);
    endtask

    task automatic check_done(input string tag);
        check({tag, "_done"},      32'(done_o),      32'd1);
        check({tag, "_error"},     32'(error_o),     32'd0);
        check({tag, "_cpu_reset"}, 32'(cpu_reset_o), 32'd0);
        check({tag, "_busy"},      32'(busy_o),      32'd0);
        check({tag, "_ready"},     32'(rx_ready_o),  32'd0);
    endtask

    initial begin
        int w0;
        int n_exp_q;

        // ---- reset ----
        idle_cycles(3);
        reset = 1'b0;
        check("rst_ready",     32'(rx_ready_o),  32'd1);
        check("rst_wen",       32'(imem_wen_o),  32'd0);
        check("rst_addr",      32'(imem_addr_o), 32'd0);
        check("rst_data",      32'(imem_data_o), 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset_o), 32'd1);
        check("rst_busy",      32'(busy_o),      32'd0);
        check("rst_done",      32'(done_o),      32'd0);
        check("rst_error",     32'(error_o),     32'd0);

        // ---- good image ----
        w0 = n_writes;
        send_good_frame(8'h0A, 0);
        check_done("good");
        check("good_writes",     n_writes - w0,       2);
        check("good_addr_hold",  32'(imem_addr_o),    32'h002);
        check("good_data_hold",  32'(imem_data_o),    32'h5678);
        idle_cycles(3);
        check("good_done_sticky", 32'(done_o), 32'd1);
        pulse_start();
        check("rearm_cpu_reset", 32'(cpu_reset_o), 32'd1);
        check("rearm_done",      32'(done_o),      32'd0);
        check("rearm_ready",     32'(rx_ready_o),  32'd1);

`ifdef LOADER_CHECKSUM_EN
        // ---- bad checksum ----
        w0 = n_writes;
        send_good_frame(8'h0B, 0);
        check("badcs_writes",    n_writes - w0,      2);
        check("badcs_error",     32'(error_o),       32'd1);
        check("badcs_done",      32'(done_o),        32'd0);
        check("badcs_cpu_reset", 32'(cpu_reset_o),   32'd1);
        pulse_start();
        check("badcs_clr_error", 32'(error_o),       32'd0);
        check("badcs_clr_cpu",   32'(cpu_reset_o),   32'd1);
`endif

        // ---- garbage before sync ----
        w0 = n_writes;
        send_byte(8'h00);
        check("garb0_ready", 32'(rx_ready_o), 32'd1);
        send_byte(8'hFF);
        check("garb1_ready", 32'(rx_ready_o), 32'd1);
        send_byte(8'h5A);
        check("garb2_ready", 32'(rx_ready_o), 32'd1);
        check("garb2_busy",  32'(busy_o),     32'd0);
        send_good_frame(8'h0A, 0);
        check_done("garb");
        check("garb_writes", n_writes - w0, 2);
        pulse_start();

        // ---- empty image (N == 0) ----
        w0 = n_writes;
        send_byte(8'hA5);
        check("empty_busy", 32'(busy_o), 32'd1);
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        idle_cycles(2);
        check_done("empty");
        check("empty_writes", n_writes - w0, 0);
        pulse_start();

        // ---- oversize length: N = 257 ----
        w0 = n_writes;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h01);
        check("ovs_error",     32'(error_o),     32'd1);
        check("ovs_cpu_reset", 32'(cpu_reset_o), 32'd1);
        check("ovs_ready",     32'(rx_ready_o),  32'd0);
        idle_cycles(2);
        check("ovs_writes",    n_writes - w0,    0);
        pulse_start();

        // ---- 10 idle cycles mid-frame survive the timeout ----
        w0 = n_writes;
        send_good_frame(8'h0A, 10);
        check_done("gap10");
        check("gap10_writes", n_writes - w0, 2);
        pulse_start();

        // ---- 15 idle cycles after the length low byte trip the timeout ----
        w0 = n_writes;
        send_byte(8'hA5);
        send_byte(8'h02);
        idle_cycles(14);
        check("tmo14_error", 32'(error_o), 32'd0);
        check("tmo14_busy",  32'(busy_o),  32'd1);
        idle_cycles(1);
        check("tmo15_error", 32'(error_o), 32'd1);
        check("tmo15_busy",  32'(busy_o),  32'd0);
        check("tmo_writes",  n_writes - w0, 0);
        pulse_start();

        // ---- reset mid-frame ----
        w0 = n_writes;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h34);
        reset = 1'b1;
        idle_cycles(1);
        reset = 1'b0;
        check("mrst_busy",      32'(busy_o),      32'd0);
        check("mrst_ready",     32'(rx_ready_o),  32'd1);
        check("mrst_cpu_reset", 32'(cpu_reset_o), 32'd1);
        check("mrst_addr",      32'(imem_addr_o), 32'd0);
        idle_cycles(3);
        check("mrst_writes",    n_writes - w0,    0);
        w0 = n_writes;
        send_good_frame(8'h0A, 0);
        check_done("after_rst");
        check("after_rst_writes", n_writes - w0, 2);

        n_exp_q = exp_q.size();
        check("scoreboard_drained", n_exp_q, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected $finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
